// File: rtl/moa_sum_monitor.sv
// moa_sum_monitor
//   Result monitor for a pipelined multi-operand adder. Recomputes the
//   reference sum of the operand bus, delays it by the adder latency LAT,
//   compares it against the adder output and keeps per-run statistics.
//
//   Build option: define MOA_MON_CAPTURE_EN to build the first-mismatch
//   capture registers; otherwise first_err_exp/first_err_got read as 0.
//
//   Ports:
//     clk            clock
//     rst_n          asynchronous active-low reset
//     start          single-cycle pulse, begins (or restarts) a run
//     in_valid       x_bus carries a valid operand set this cycle
//     x_bus          N_OPS operands, x0 in the least significant W bits
//     summ           adder output under test
//     busy           run in progress (FILL or CHECK)
//     done           run finished, held until the next start
//     pass           done with zero mismatches
//     chk_cnt        comparisons performed in this run
//     err_cnt        mismatches in this run (saturating)
//     first_err_exp  expected sum at the first mismatch
//     first_err_got  observed summ at the first mismatch
module moa_sum_monitor #(
    parameter int unsigned N_OPS   = 8,
    parameter int unsigned W       = 8,
    parameter int unsigned SUM_W   = 11,
    parameter int unsigned LAT     = 2,
    parameter int unsigned N_CHECK = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N_OPS*W-1:0]   x_bus,
    input  logic [SUM_W-1:0]     summ,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          chk_cnt,
    output logic [15:0]          err_cnt,
    output logic [SUM_W-1:0]     first_err_exp,
    output logic [SUM_W-1:0]     first_err_got
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_CHECK, S_DONE} state_e;

    state_e                       state_q, state_d;
    logic [3:0]                   fill_q, fill_d;
    logic [LAT-1:0]               vld_q, vld_d;
    logic [LAT-1:0][SUM_W-1:0]    pipe_q, pipe_d;
    logic [15:0]                  chk_cnt_q, chk_cnt_d;
    logic [15:0]                  err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0]             ref_sum;
    logic                         cmp_fire;
    logic                         mismatch;
    logic                         last_cmp;

    // Reference sum; SUM_W is wide enough that no carry is lost.
    always_comb begin
        ref_sum = '0;
        for (int unsigned i = 0; i < N_OPS; i++) begin
            ref_sum = ref_sum + SUM_W'(x_bus[i*W +: W]);
        end
    end

    assign cmp_fire = vld_q[LAT-1] && (state_q == S_CHECK);
    assign mismatch = cmp_fire && (pipe_q[LAT-1] != summ);
    assign last_cmp = cmp_fire && (chk_cnt_q == 16'(N_CHECK - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // Next state; start from any state wins over the final compare
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (start) begin
            state_d = S_FILL;
            fill_d  = '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (fill_q == 4'(LAT - 1)) state_d = S_CHECK;
                    else                       fill_d  = fill_q + 4'd1;
                end
                S_CHECK: if (last_cmp) state_d = S_DONE;
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        busy = (state_q == S_FILL) || (state_q == S_CHECK);
        done = (state_q == S_DONE);
        pass = done && (err_cnt_q == '0);
    end

    // Delay line: shifts every edge, stage 0 only accepts while busy
    always_comb begin
        vld_d  = vld_q;
        pipe_d = pipe_q;
        for (int unsigned i = 1; i < LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            pipe_d[i] = pipe_q[i-1];
        end
        vld_d[0]  = in_valid & busy;
        pipe_d[0] = ref_sum;
        if (start) vld_d = '0;
    end

    always_comb begin
        chk_cnt_d = chk_cnt_q;
        err_cnt_d = err_cnt_q;
        if (start) begin
            chk_cnt_d = '0;
            err_cnt_d = '0;
        end else if (cmp_fire) begin
            chk_cnt_d = chk_cnt_q + 16'd1;
            if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            pipe_q    <= '0;
            chk_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            vld_q     <= vld_d;
            pipe_q    <= pipe_d;
            chk_cnt_q <= chk_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign chk_cnt = chk_cnt_q;
    assign err_cnt = err_cnt_q;

`ifdef MOA_MON_CAPTURE_EN
    logic [SUM_W-1:0] fe_exp_q, fe_exp_d;
    logic [SUM_W-1:0] fe_got_q, fe_got_d;

    // err_cnt_q still zero identifies the first mismatch of the run
    always_comb begin
        fe_exp_d = fe_exp_q;
        fe_got_d = fe_got_q;
        if (start) begin
            fe_exp_d = '0;
            fe_got_d = '0;
        end else if (mismatch && (err_cnt_q == '0)) begin
            fe_exp_d = pipe_q[LAT-1];
            fe_got_d = summ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_exp_q <= '0;
            fe_got_q <= '0;
        end else begin
            fe_exp_q <= fe_exp_d;
            fe_got_q <= fe_got_d;
        end
    end

    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;
`else
    assign first_err_exp = '0;
    assign first_err_got = '0;
`endif

endmodule
